jh_round_engine: RTL and testbench
==================================

// Module: jh_round_engine
// PURPOSE
//  Iterative, parametrised JH-style permutation engine: runs ROUNDS bit-sliced rounds over a 4*NIB-bit state.
//  Each round has three steps: an S-box layer selected per nibble by a round constant, a pairwise linear mix L, and a nibble permutation.
//  The round constant is generated internally and evolves every round.
//  Sits between the hash message-injection logic and the finalisation stage; uses a valid/ready handshake on both sides.
// PARAMETERS
//  NIB     64     state nibbles; STATE_W = 4*NIB; must be a multiple of 16, >= 16
//  ROUNDS  42     rounds per job
//  UNROLL  1      rounds computed per clock; must divide ROUNDS
//  RC0     'h0    initial round constant, NIB bits (rc bit i, i.e. rc[NIB-1-i], selects the S-box for nibble i)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        job request
//  in_ready   out  1        engine can accept a job
//  in_state   in   STATE_W  initial state; nibble 0 = in_state[STATE_W-1 -: 4]
//  out_valid  out  1        result available
//  out_ready  in   1        consumer accepts result
//  out_state  out  STATE_W  permuted state
//  busy       out  1        rounds in progress
//  flush      in   1        (only with JH_FLUSH_EN) abort current job
// BEHAVIOUR
//  Reset (async, any time, including mid-job):
//   - FSM goes to IDLE; rc = RC0; round counter = 0.
//   - Output values: in_ready=1, out_valid=0, busy=0, out_state=0.
//  FSM:
//   - IDLE -> RUN on in_valid&&in_ready: latch in_state, rc=RC0, cnt=0.
//   - RUN: apply UNROLL rounds per cycle; cnt += UNROLL; enter DONE once cnt reaches ROUNDS.
//   - DONE: out_valid=1, out_state held stable until out_valid&&out_ready.
//   - DONE with out_ready=1 and in_valid=1 accepts the new job in the same cycle -> RUN (back-to-back).
//   - DONE with out_ready=1 and in_valid=0 -> IDLE.
//  Output values by state:
//   - in_ready = 1 in IDLE, and = out_ready in DONE; 0 in RUN.
//   - busy = 1 only in RUN.
//  Latency: out_valid rises exactly ROUNDS/UNROLL cycles after the accept edge.
//   - in_valid while in_ready=0 is ignored (not queued).
//   - out_ready is ignored outside DONE.
//  Round r (state s, constant rc):
//   1. S-layer: nibble i -> S1[v] if rc bit i else S0[v].
//      S0 = 9,0,4,b,d,c,3,f,1,a,2,6,7,5,8,e
//      S1 = 3,c,6,d,5,7,1,9,f,2,0,4,b,a,e,8
//   2. L on pair j (A = nibble 2j, B = nibble 2j+1), bit 0 = nibble MSB:
//      D0=B0^A1  D1=B1^A2  D2=B2^A3^A0  D3=B3^A0
//      C0=A0^D1  C1=A1^D2  C2=A2^D3^D0  C3=A3^D0
//      C goes to position 2j, D to position 2j+1.
//   3. Permutation: swap the two nibbles of every odd pair j; then all even-index nibbles, in order, form the upper half and all odd-index nibbles the lower half.
//   4. rc update: the same round (steps 1-3, all S0, width NIB bits = NIB/4 nibbles) is applied to rc.
//  UNROLL > 1: the rounds are chained combinationally; the result is identical to UNROLL=1.
//  No arithmetic beyond the counter: cnt width is clog2(ROUNDS+1), and cnt never wraps.
// CONFIGURATION
//  JH_FLUSH_EN defined:
//   - flush=1 in any state -> next cycle IDLE, out_valid=0, cnt=0, rc=RC0; no result is emitted.
//   - flush has priority over in_valid and out_ready in the same cycle.
//  JH_FLUSH_EN undefined: the flush port is absent and a job always completes.
// TESTING
//  1. NIB=16, ROUNDS=1, UNROLL=1, RC0=0, in_state=0 -> after 1 cycle out_valid=1, out_state=64'ha8a8a8a88a8a8a8a.
//  2. Defaults, random in_state vs C model, UNROLL=1, 2, 3, 6 -> identical out_state; latency 42, 21, 14, 7.
//  3. Hold out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0; then out_ready=1 with in_valid=1 -> new job accepted that cycle.
//  4. Assert rst at cnt=20 -> out_valid=0, busy=0, in_ready=1 immediately; the next job's result matches the model.
//  5. in_valid pulsed during RUN -> ignored; exactly one out_valid per accepted job.
//  6. JH_FLUSH_EN: flush at cnt=5 -> IDLE next cycle, no out_valid; next job gives the correct result.

Source files
------------

// File: rtl/jh_round_engine_if.sv
// Valid/ready job and result bus for jh_round_engine.
// The engine uses the slave side; the job source and result consumer use the master side.
interface jh_round_engine_if #(
    parameter int unsigned STATE_W = 256
);
    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_state;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_state;
    logic               busy;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/jh_round_engine.sv
// Iterative JH-style permutation engine: UNROLL rounds per clock over a 4*NIB-bit state.
// Defining JH_FLUSH_EN adds a flush input that aborts the job in progress.
module jh_round_engine #(
    parameter int unsigned    NIB    = 64,
    parameter int unsigned    ROUNDS = 42,
    parameter int unsigned    UNROLL = 1,
    parameter logic [NIB-1:0] RC0    = '0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef JH_FLUSH_EN
    input  logic             flush,
`endif
    jh_round_engine_if.slave bus
);
    localparam int unsigned STATE_W = 4 * NIB;
    localparam int unsigned RC_NIB  = NIB / 4;
    localparam int unsigned CNT_W   = $clog2(ROUNDS + 1);
    localparam logic [63:0] S0_TAB  = 64'h904bdc3f1a26758e;
    localparam logic [63:0] S1_TAB  = 64'h3c6d5719f204bae8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] v, input logic sel);
        logic [63:0] tab;
        tab = sel ? S1_TAB : S0_TAB;
        return tab[63 - 4 * int'(v) -: 4];
    endfunction

    // Nibble MSB is bit 0 of the mix equations, so bit k lives at index [3-k].
    function automatic logic [7:0] lmix(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] c;
        logic [3:0] d;
        d[3] = b[3] ^ a[2];
        d[2] = b[2] ^ a[1];
        d[1] = b[1] ^ a[0] ^ a[3];
        d[0] = b[0] ^ a[3];
        c[3] = a[3] ^ d[2];
        c[2] = a[2] ^ d[1];
        c[1] = a[1] ^ d[0] ^ d[3];
        c[0] = a[0] ^ d[3];
        return {c, d};
    endfunction

    function automatic logic [STATE_W-1:0] state_round(input logic [STATE_W-1:0] s,
                                                       input logic [NIB-1:0]     rc);
        logic [3:0]         y [NIB];
        logic [STATE_W-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < NIB / 2; j++) begin
            {y[2*j], y[2*j+1]} = lmix(sbox(s[STATE_W-1-8*j -: 4], rc[NIB-1-2*j]),
                                      sbox(s[STATE_W-5-8*j -: 4], rc[NIB-2-2*j]));
        end
        // Odd pairs swap first; pair k then feeds nibble k (upper half) and NIB/2+k (lower half).
        for (int unsigned k = 0; k < NIB / 2; k++) begin
            r[STATE_W-1-4*k -: 4]   = k[0] ? y[2*k+1] : y[2*k];
            r[STATE_W/2-1-4*k -: 4] = k[0] ? y[2*k]   : y[2*k+1];
        end
        return r;
    endfunction

    function automatic logic [NIB-1:0] rc_round(input logic [NIB-1:0] rc);
        logic [3:0]     y [RC_NIB];
        logic [NIB-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < RC_NIB / 2; j++) begin
            {y[2*j], y[2*j+1]} = lmix(sbox(rc[NIB-1-8*j -: 4], 1'b0),
                                      sbox(rc[NIB-5-8*j -: 4], 1'b0));
        end
        for (int unsigned k = 0; k < RC_NIB / 2; k++) begin
            r[NIB-1-4*k -: 4]   = k[0] ? y[2*k+1] : y[2*k];
            r[NIB/2-1-4*k -: 4] = k[0] ? y[2*k]   : y[2*k+1];
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [STATE_W-1:0] st_q, st_d, st_nx;
    logic [NIB-1:0]     rc_q, rc_d, rc_nx;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nx;
    logic               accept;

    assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_RUN);
    assign bus.out_state = (state_q == S_DONE) ? st_q : '0;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        st_nx = st_q;
        rc_nx = rc_q;
        for (int unsigned u = 0; u < UNROLL; u++) begin
            st_nx = state_round(st_nx, rc_nx);
            rc_nx = rc_round(rc_nx);
        end
        cnt_nx = cnt_q + CNT_W'(UNROLL);
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rc_d    = rc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = S_RUN;
                    st_d    = bus.in_state;
                    rc_d    = RC0;
                    cnt_d   = '0;
                end else if ((state_q == S_DONE) && bus.out_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                st_d  = st_nx;
                rc_d  = rc_nx;
                cnt_d = cnt_nx;
                if (cnt_nx == CNT_W'(ROUNDS)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef JH_FLUSH_EN
        if (flush) begin
            state_d = S_IDLE;
            rc_d    = RC0;
            cnt_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            rc_q    <= RC0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rc_q    <= rc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_jh_round_engine.sv
// Directed bench for jh_round_engine: hand-computed vectors on two 16-nibble single-round
// instances, and a reference model against four default-size instances with UNROLL 1/2/3/6.
module tb_jh_round_engine;
    logic clk = 1'b0;
    logic rst;
`ifdef JH_FLUSH_EN
    logic flush;
`endif
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        sm_valid, sm_ready;
    logic [63:0] sm_state;
    logic [1:0]  sm_ov, sm_ir, sm_busy;
    logic [63:0] sm_os [2];

    logic         dd_valid, dd_ready;
    logic [255:0] dd_state;
    logic [3:0]   dd_ov, dd_ir, dd_busy;
    logic [255:0] dd_os [4];

    localparam int LAT [4] = '{42, 21, 14, 7};

    for (genvar g = 0; g < 2; g++) begin : g_sm
        jh_round_engine_if #(.STATE_W(64)) bus ();
        assign bus.in_valid  = sm_valid;
        assign bus.in_state  = sm_state;
        assign bus.out_ready = sm_ready;
        jh_round_engine #(
            .NIB(16), .ROUNDS(1), .UNROLL(1), .RC0((g == 0) ? 16'h0000 : 16'hffff)
        ) u_dut (
            .clk(clk),
            .rst(rst),
`ifdef JH_FLUSH_EN
            .flush(flush),
`endif
            .bus(bus)
        );
        assign sm_ov[g]   = bus.out_valid;
        assign sm_ir[g]   = bus.in_ready;
        assign sm_busy[g] = bus.busy;
        assign sm_os[g]   = bus.out_state;
    end

    for (genvar g = 0; g < 4; g++) begin : g_dd
        localparam int unsigned U = (g == 3) ? 6 : g + 1;
        jh_round_engine_if #(.STATE_W(256)) bus ();
        assign bus.in_valid  = dd_valid;
        assign bus.in_state  = dd_state;
        assign bus.out_ready = dd_ready;
        jh_round_engine #(
            .NIB(64), .ROUNDS(42), .UNROLL(U), .RC0(64'h0)
        ) u_dut (
            .clk(clk),
            .rst(rst),
`ifdef JH_FLUSH_EN
            .flush(flush),
`endif
            .bus(bus)
        );
        assign dd_ov[g]   = bus.out_valid;
        assign dd_ir[g]   = bus.in_ready;
        assign dd_busy[g] = bus.busy;
        assign dd_os[g]   = bus.out_state;
    end

    localparam logic [3:0] SB0 [16] = '{4'h9, 4'h0, 4'h4, 4'hb, 4'hd, 4'hc, 4'h3, 4'hf,
                                        4'h1, 4'ha, 4'h2, 4'h6, 4'h7, 4'h5, 4'h8, 4'he};
    localparam logic [3:0] SB1 [16] = '{4'h3, 4'hc, 4'h6, 4'hd, 4'h5, 4'h7, 4'h1, 4'h9,
                                        4'hf, 4'h2, 4'h0, 4'h4, 4'hb, 4'ha, 4'he, 4'h8};

    // One round over the top n nibbles of v; sel[63-i] picks the S-box for nibble i.
    function automatic logic [255:0] m_round(input logic [255:0] v, input int n,
                                             input logic [63:0] sel);
        logic [3:0]   x [64];
        logic [3:0]   y [64];
        logic [3:0]   a, b;
        logic [255:0] r;
        int           q, dst;
        r = '0;
        for (int i = 0; i < n; i++)
            x[i] = sel[63-i] ? SB1[v[255-4*i -: 4]] : SB0[v[255-4*i -: 4]];
        for (int j = 0; j < n / 2; j++) begin
            a = x[2*j];
            b = x[2*j+1];
            y[2*j]   = {a[3]^b[2]^a[1], a[2]^b[1]^a[0]^a[3],
                        a[1]^b[0]^a[3]^b[3]^a[2], a[0]^b[3]^a[2]};
            y[2*j+1] = {b[3]^a[2], b[2]^a[1], b[1]^a[0]^a[3], b[0]^a[3]};
        end
        for (int p = 0; p < n; p++) begin
            q   = ((p / 2) % 2 == 1) ? (p ^ 1) : p;
            dst = (q % 2 == 0) ? q / 2 : n / 2 + q / 2;
            r[255-4*dst -: 4] = y[p];
        end
        return r;
    endfunction

    function automatic logic [255:0] model_job(input logic [255:0] din);
        logic [255:0] s, t;
        logic [63:0]  rc;
        s  = din;
        rc = '0;
        for (int r = 0; r < 42; r++) begin
            s  = m_round(s, 64, rc);
            t  = m_round({rc, 192'h0}, 16, 64'h0);
            rc = t[255:192];
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a job on the four default instances (from IDLE or as a back-to-back accept
    // from DONE), pulses in_valid mid-run, and holds out_ready low 11 cycles past the last result.
    task automatic job(input logic [255:0] din, input string tag);
        logic [255:0] exp;
        int           lat [4];
        int           rises [4];
        logic [3:0]   prev;
        exp   = model_job(din);
        lat   = '{default: 0};
        rises = '{default: 0};
        dd_state = din;
        dd_valid = 1'b1;
        dd_ready = 1'b1;
        #1 check({tag, "_in_ready_accept"}, dd_ir, 4'hf);
        @(negedge clk);
        dd_valid = 1'b0;
        dd_ready = 1'b0;
        check({tag, "_busy"}, dd_busy, 4'hf);
        check({tag, "_in_ready_run"}, dd_ir, 4'h0);
        prev = '0;
        for (int c = 0; c <= 52; c++) begin
            for (int g = 0; g < 4; g++) begin
                if (dd_ov[g] && !prev[g]) begin
                    rises[g]++;
                    lat[g] = c;
                end
            end
            prev = dd_ov;
            dd_valid = (c == 3);
            @(negedge clk);
        end
        for (int g = 0; g < 4; g++) begin
            check($sformatf("%s_lat_u%0d", tag, g), lat[g], LAT[g]);
            check($sformatf("%s_rises_u%0d", tag, g), rises[g], 1);
            check($sformatf("%s_state_u%0d", tag, g), dd_os[g], exp);
        end
        check({tag, "_held_valid"}, dd_ov, 4'hf);
        check({tag, "_held_in_ready"}, dd_ir, 4'h0);
    endtask

    task automatic release_to_idle(input string tag);
        logic [3:0] seen;
        dd_ready = 1'b1;
        dd_valid = 1'b0;
        @(negedge clk);
        dd_ready = 1'b0;
        check({tag, "_valid"}, dd_ov, 4'h0);
        check({tag, "_busy"}, dd_busy, 4'h0);
        check({tag, "_in_ready"}, dd_ir, 4'hf);
        check({tag, "_state"}, dd_os[0], 256'h0);
        seen = '0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | dd_ov;
        end
        check({tag, "_no_extra"}, seen, 4'h0);
    endtask

    initial begin
        logic [255:0] v1, v2, v3;
        logic [3:0]   seen;
        v1 = '0;
        v2 = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
        v3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        rst      = 1'b1;
        sm_valid = 1'b0;
        sm_ready = 1'b0;
        sm_state = '0;
        dd_valid = 1'b0;
        dd_ready = 1'b0;
        dd_state = '0;
`ifdef JH_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_in_ready", {sm_ir, dd_ir}, 6'h3f);
        check("rst_out_valid", {sm_ov, dd_ov}, 6'h00);
        check("rst_busy", {sm_busy, dd_busy}, 6'h00);
        check("rst_sm_state", sm_os[0], 256'h0);
        check("rst_dd_state", dd_os[0], 256'h0);
        rst = 1'b0;
        @(negedge clk);

        sm_state = '0;
        sm_valid = 1'b1;
        @(negedge clk);
        sm_valid = 1'b0;
        check("sm_busy", sm_busy, 2'b11);
        check("sm_in_ready_run", sm_ir, 2'b00);
        check("sm_valid_run", sm_ov, 2'b00);
        @(negedge clk);
        check("sm_valid_done", sm_ov, 2'b11);
        check("sm_zero_rc0", sm_os[0], 64'ha8a8a8a88a8a8a8a);
        check("sm_zero_rc1", sm_os[1], 64'h9595959559595959);
        check("sm_in_ready_stall", sm_ir, 2'b00);
        sm_ready = 1'b1;
        sm_valid = 1'b1;
        sm_state = '1;
        #1 check("sm_in_ready_b2b", sm_ir, 2'b11);
        @(negedge clk);
        sm_valid = 1'b0;
        sm_ready = 1'b0;
        check("sm_b2b_busy", sm_busy, 2'b11);
        @(negedge clk);
        check("sm_ones_rc0", sm_os[0], 64'hc1c1c1c11c1c1c1c);
        check("sm_ones_rc1", sm_os[1], 64'hdbdbdbdbbdbdbdbd);
        sm_ready = 1'b1;
        @(negedge clk);
        sm_ready = 1'b0;
        check("sm_idle_valid", sm_ov, 2'b00);
        check("sm_idle_in_ready", sm_ir, 2'b11);
        check("sm_idle_state", sm_os[0], 256'h0);

        job(v1, "j_zero");
        job(v2, "j_b2b");
        release_to_idle("idle1");
        job(v3, "j_rand");
        release_to_idle("idle2");

        dd_state = v2;
        dd_valid = 1'b1;
        @(negedge clk);
        dd_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", dd_ov, 4'h0);
        check("midrst_busy", dd_busy, 4'h0);
        check("midrst_in_ready", dd_ir, 4'hf);
        check("midrst_state", dd_os[0], 256'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        job(v1, "j_postrst");
        release_to_idle("idle3");

`ifdef JH_FLUSH_EN
        dd_state = v3;
        dd_valid = 1'b1;
        @(negedge clk);
        dd_valid = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        dd_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        dd_valid = 1'b0;
        check("flush_valid", dd_ov, 4'h0);
        check("flush_busy", dd_busy, 4'h0);
        check("flush_in_ready", dd_ir, 4'hf);
        seen = '0;
        repeat (45) begin
            @(negedge clk);
            seen = seen | dd_ov | dd_busy;
        end
        check("flush_no_result", seen, 4'h0);
        job(v2, "j_postflush");
        release_to_idle("idle4");
`else
        seen = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
